// File: rtl/anim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : anim_pkg
// Description : Shared widths, state encoding and constants for the 7-segment
//               animation frame sequencer and its limit lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package anim_pkg;

    localparam int ANIM_W  = 5;
    localparam int FRAME_W = 5;

    localparam logic [ANIM_W-1:0] ANIM_LAST = 5'd31;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Divides clk down to a one-cycle frame-rate tick every TICK_DIV
//               enabled cycles; i_clr restarts the count from zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 12000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int              CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = i_en && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : frame_sequencer
// Description : Steps through the frames of the selected animation, with
//               optional auto-advance to the next animation on frame wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_sequencer
    import anim_pkg::*;
#(
    parameter int TICK_DIV = 12000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               auto_adv,
    input  logic [ANIM_W-1:0]  anim_sel,
    input  logic [FRAME_W-1:0] limit,
    output logic [ANIM_W-1:0]  anim_cur,
    output logic [FRAME_W-1:0] frame,
    output logic               step,
    output logic               wrap
);

    state_t             r_state, w_state_n;
    logic [ANIM_W-1:0]  r_anim,  w_anim_n;
    logic [FRAME_W-1:0] r_frame, w_frame_n;
    logic               r_step,  w_step_n;
    logic               r_wrap,  w_wrap_n;

    logic               w_tick;
    logic               w_reload;
    logic               w_clr;
    logic [FRAME_W-1:0] w_last_frame;

    // The prescaler is held at zero while the limit lookup settles.
    assign w_clr = en && (w_reload || (r_state == LOAD));

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_en   (en),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    // A zero limit is played as a single-frame animation.
    assign w_last_frame = (limit == '0) ? '0 : limit - FRAME_W'(1);

    always_comb begin
        w_state_n = r_state;
        w_anim_n  = r_anim;
        w_frame_n = r_frame;
        w_step_n  = 1'b0;
        w_wrap_n  = 1'b0;
        w_reload  = 1'b0;

        if (en) begin
            if (!auto_adv && (anim_sel != r_anim)) begin
                w_reload  = 1'b1;
                w_anim_n  = anim_sel;
                w_frame_n = '0;
                w_state_n = LOAD;
            end else if (r_state == LOAD) begin
                w_state_n = RUN;
            end else if (w_tick) begin
                w_step_n = 1'b1;
                if (r_frame >= w_last_frame) begin
                    w_frame_n = '0;
                    w_wrap_n  = 1'b1;
                    if (auto_adv) begin
                        w_anim_n  = (r_anim == ANIM_LAST) ? '0 : r_anim + ANIM_W'(1);
                        w_state_n = LOAD;
                    end
                end else begin
                    w_frame_n = r_frame + FRAME_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
            r_anim  <= '0;
            r_frame <= '0;
            r_step  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_anim  <= w_anim_n;
            r_frame <= w_frame_n;
            r_step  <= w_step_n;
            r_wrap  <= w_wrap_n;
        end
    end

    assign anim_cur = r_anim;
    assign frame    = r_frame;
    assign step     = r_step;
    assign wrap     = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_sequencer
// Description : Directed self-checking bench for frame_sequencer (TICK_DIV=4)
//               with a stub frame-limit lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_sequencer;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       auto_adv;
    logic [4:0] anim_sel;
    logic [4:0] limit;
    logic [4:0] anim_cur;
    logic [4:0] frame;
    logic       step;
    logic       wrap;

    int total = 0;
    int bad   = 0;

    frame_sequencer #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .auto_adv (auto_adv),
        .anim_sel (anim_sel),
        .limit    (limit),
        .anim_cur (anim_cur),
        .frame    (frame),
        .step     (step),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (anim_cur)
            5'd0:    limit = 5'd10;
            5'd1:    limit = 5'd12;
            5'd5:    limit = 5'd0;
            5'd7:    limit = 5'd2;
            5'd31:   limit = 5'd3;
            default: limit = 5'd4;
        endcase
    end

    typedef struct {
        logic       en;
        logic       auto_adv;
        logic [4:0] sel;
        logic [4:0] frame;
        logic [4:0] anim;
        logic       step;
        logic       wrap;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // n edges; pulses must stay low until the last, which must be a step.
    task automatic step_after(input int n, input int fr, input int an, input int wr);
        for (int i = 0; i < n - 1; i++) begin
            edge_step();
            chk("idle_step", int'(step), 0);
            chk("idle_wrap", int'(wrap), 0);
        end
        edge_step();
        chk("step", int'(step), 1);
        chk("wrap", int'(wrap), wr);
        chk("frame", int'(frame), fr);
        chk("anim", int'(anim_cur), an);
    endtask

    task automatic run_first();
        step_after(5, 1, 0, 0);
        for (int f = 2; f <= 9; f++) step_after(4, f, 0, 0);
        step_after(4, 0, 0, 1);
        edge_step();
        chk("pulse_len_step", int'(step), 0);
        chk("pulse_len_wrap", int'(wrap), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Manual reload on a tick cycle, then anim7 (limit 2) playback.
        vecs[0]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 5'd7, 5'd0, 5'd7, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0};

        rst      = 1'b1;
        en       = 1'b1;
        auto_adv = 1'b0;
        anim_sel = 5'd0;
        edge_step();
        edge_step();
        chk("rst_frame", int'(frame), 0);
        chk("rst_anim", int'(anim_cur), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_wrap", int'(wrap), 0);
        rst = 1'b0;

        run_first();

        for (int i = 0; i < 16; i++) begin
            en       = vecs[i].en;
            auto_adv = vecs[i].auto_adv;
            anim_sel = vecs[i].sel;
            edge_step();
            chk($sformatf("vec%0d_frame", i), int'(frame), int'(vecs[i].frame));
            chk($sformatf("vec%0d_anim", i), int'(anim_cur), int'(vecs[i].anim));
            chk($sformatf("vec%0d_step", i), int'(step), int'(vecs[i].step));
            chk($sformatf("vec%0d_wrap", i), int'(wrap), int'(vecs[i].wrap));
        end

        // Auto-advance from anim31 frame 2 wraps to anim0.
        anim_sel = 5'd31;
        edge_step();
        chk("sel31_anim", int'(anim_cur), 31);
        chk("sel31_frame", int'(frame), 0);
        chk("sel31_step", int'(step), 0);
        step_after(5, 1, 31, 0);
        step_after(4, 2, 31, 0);
        auto_adv = 1'b1;
        step_after(4, 0, 0, 1);
        step_after(5, 1, 0, 0);

        // Zero limit: every tick is a step and a wrap at frame 0.
        auto_adv = 1'b0;
        anim_sel = 5'd5;
        edge_step();
        chk("sel5_anim", int'(anim_cur), 5);
        chk("sel5_frame", int'(frame), 0);
        chk("sel5_step", int'(step), 0);
        chk("sel5_wrap", int'(wrap), 0);
        step_after(5, 0, 5, 1);
        step_after(4, 0, 5, 1);

        // Freeze with prescaler at 2 and frame 4.
        anim_sel = 5'd0;
        edge_step();
        chk("sel0_anim", int'(anim_cur), 0);
        step_after(5, 1, 0, 0);
        step_after(4, 2, 0, 0);
        step_after(4, 3, 0, 0);
        step_after(4, 4, 0, 0);
        edge_step();
        edge_step();
        chk("pre_freeze_step", int'(step), 0);
        en       = 1'b0;
        anim_sel = 5'd1;
        for (int i = 0; i < 20; i++) begin
            edge_step();
            chk("frz_step", int'(step), 0);
            chk("frz_wrap", int'(wrap), 0);
            chk("frz_frame", int'(frame), 4);
            chk("frz_anim", int'(anim_cur), 0);
        end
        anim_sel = 5'd0;
        en       = 1'b1;
        step_after(2, 5, 0, 0);

        // Asynchronous reset between clock edges.
        edge_step();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_frame", int'(frame), 0);
        chk("arst_anim", int'(anim_cur), 0);
        chk("arst_step", int'(step), 0);
        chk("arst_wrap", int'(wrap), 0);
        edge_step();
        edge_step();
        rst = 1'b0;
        run_first();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Steps through the frames of the selected 7-segment animation.
- Drives the animation index into the per-animation frame-limit lookup and consumes the returned frame count.
- Produces the current frame number and animation index for the segment pattern ROM.
- Generates its own frame-rate tick from the system clock; optionally auto-advances to the next animation on wrap.

Parameters:
- TICK_DIV, 12000000, clock cycles per frame step (1 Hz at 12 MHz); legal range >= 2.
- CNT_W, $clog2(TICK_DIV), prescaler width (derived, not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable; 0 freezes prescaler, frame and animation
- auto_adv  in  1  1 = advance animation on frame wrap; 0 = follow anim_sel
- anim_sel  in  5  user-selected animation (manual mode)
- limit  in  5  frame count for anim_cur, from the limit lookup (combinational)
- anim_cur  out  5  animation index being played; feeds the limit lookup and pattern ROM
- frame  out  5  current frame, 0..limit-1
- step  out  1  one-cycle pulse on every frame update
- wrap  out  1  one-cycle pulse when frame returns to 0 from the last frame

Behaviour:
- Reset values: state LOAD, prescaler 0, frame 0, anim_cur 0, step 0, wrap 0.
- Reset is asserted asynchronously; release is assumed synchronous to clk.
- Prescaler, while en=1:
  - counts 0..TICK_DIV-1, then returns to 0;
  - tick = (count == TICK_DIV-1) && en;
  - en=0 holds the count.
- FSM states:
  - LOAD: one settle cycle so limit reflects a new anim_cur. The prescaler is held at 0 and no tick is taken. Goes to RUN next cycle (when en=1).
  - RUN: normal stepping.
- Tick in RUN, with eff_limit = (limit==0) ? 1 : limit:
  - frame >= eff_limit-1: frame <= 0, wrap=1, step=1. If auto_adv=1, anim_cur <= anim_cur+1 (mod 32, 31->0) and state <= LOAD.
  - otherwise: frame <= frame+1, step=1.
  - The ">=" comparison also recovers cleanly if limit shrinks under a running frame.
- Manual selection (auto_adv=0, en=1), checked every cycle in any state:
  - if anim_sel != anim_cur: anim_cur <= anim_sel, frame <= 0, prescaler <= 0, state <= LOAD;
  - no step or wrap pulse is produced for a reload.
  - Reload has priority over a simultaneous tick: the tick is dropped.
- auto_adv=1: anim_sel is ignored. When auto_adv drops to 0, a mismatch triggers a reload on the next cycle.
- en=0: all state held and step/wrap forced 0. Selection compare is also suspended.
- Outputs are registered. frame and anim_cur update on the clock edge after the tick; step and wrap are high in that same cycle.
- Latency: first step occurs TICK_DIV+1 cycles after reset release (1 LOAD cycle + TICK_DIV prescaler cycles).

Decomposition:
- Shared package anim_pkg:
  - ANIM_W=5, FRAME_W=5;
  - state enum {LOAD, RUN};
  - ANIM_LAST=5'd31.
  - The limit lookup uses the same widths.
- One natural sub-module: tick_prescaler (TICK_DIV, en -> tick, clr input for reload). The FSM and counters stay in frame_sequencer.

Test Plan (TICK_DIV=4; bench stubs the limit lookup: anim0=10, anim1=12, anim7=2, anim31=3, anim5=0):
- Reset, en=1, auto_adv=0, anim_sel=0:
  - first step at cycle 5 after release, frame 1;
  - frame walks 0..9 every 4 cycles;
  - after frame 9 the next tick gives frame 0 with wrap=1 and step=1 for exactly one cycle.
- Manual reload: anim_sel 0->7 mid-playback, issued on the same cycle as a tick:
  - anim_cur=7, frame=0, no step/wrap;
  - frames then alternate 0,1,0,... with wrap on every second step.
- Auto-advance: auto_adv=1, anim_cur=31 at frame 2:
  - next tick gives frame 0, wrap=1, anim_cur=0;
  - one LOAD cycle, then 4 cycles to the next step.
- Limit 0 on anim5: frame stays 0; every tick asserts both step and wrap.
- en low for 20 cycles mid-count (prescaler at 2, frame 4):
  - no pulses while low; frame/anim_cur unchanged;
  - after en rises, step arrives exactly 2 cycles later with frame 5.
- rst asserted asynchronously mid-RUN (between clock edges):
  - all outputs zero immediately;
  - on release, behaviour identical to the first scenario.
